// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package ifetch_pkg;
  typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/ifetch_fifo.sv
// Registered-output synchronous FIFO holding fetched {pc, instr} entries.
module ifetch_fifo #(
  parameter  int FIFO_DEPTH = 2,
  parameter  int W          = 64,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // The credit rule upstream must make this unreachable.
  always_ff @(posedge clk) begin
    if (reset && !flush) assert (!(push && full && !do_pop)) else $error("ifetch_fifo overflow");
  end
endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, issues 1-cycle-latency reads, buffers results for decode.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               mem_en,
  output logic [31:0]        mem_addr,
  input  logic [31:0]        mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               halted,
  output logic               misalign_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int UW = CW + 1;

  state_t        state;
  logic [31:0]   pc, tag_pc;
  logic          epoch, tag_epoch, inflight;
  logic [CW-1:0] count;
  logic [UW-1:0] used;
  logic          deq, push, credit_ok;
  entry_t        head, resp;

  assign instr_valid = (count != '0);
  assign deq         = instr_valid & instr_ready;
  assign used        = UW'(count) + UW'(inflight) - UW'(deq);
  assign credit_ok   = (used < UW'(FIFO_DEPTH));
  // Gating with reset keeps the strobe low while reset is held and lets the
  // first fetch go out in the very first cycle after release.
  assign mem_en      = reset & (state == FETCH) & ~halt_req & ~redirect_valid & credit_ok;
  assign mem_addr    = pc;
  assign push        = inflight & (tag_epoch == epoch);
  assign resp        = '{pc: tag_pc, instr: mem_rdata};
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;
  assign halted      = (state == HALTED) & halt_req & ~inflight;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      epoch        <= 1'b0;
      inflight     <= 1'b0;
      tag_epoch    <= 1'b0;
      tag_pc       <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid & (redirect_pc[1:0] != 2'b00);
      inflight     <= mem_en;
      if (mem_en) begin
        tag_epoch <= epoch;
        tag_pc    <= pc;
      end
      if (redirect_valid) begin
        pc    <= {redirect_pc[31:2], 2'b00};
        epoch <= ~epoch;
      end else if (mem_en) begin
        pc <= pc + 32'd4;
      end
      case (state)
        FETCH:  if (halt_req && !inflight) state <= HALTED;
        HALTED: if (!halt_req) state <= FETCH;
      endcase
    end
  end

  // Flush on redirect outranks the push of a response landing in the same cycle.
  ifetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (resp),
    .pop       (deq),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl; memory word n returns 0x1000_0000+n.
module tb_ifetch_ctrl;
  logic        clk = 1'b0, reset = 1'b0, halt_req = 1'b0, redirect_valid = 1'b0, instr_ready = 1'b1;
  logic [31:0] redirect_pc = '0, mem_rdata = '0;
  logic        mem_en, instr_valid, halted, misalign_err;
  logic [31:0] mem_addr, instr, instr_pc;
  int          passed = 0, total = 0, fails = 0;

  ifetch_ctrl dut (
    .clk(clk), .reset(reset), .halt_req(halt_req), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= 32'h1000_0000 + (mem_addr >> 2);

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic head_chk(input string tag, input logic [31:0] pc);
    chk({tag, "_vld"}, instr_valid, 1);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_instr"}, instr, word(pc));
  endtask

  task automatic issue_chk(input string tag, input logic [31:0] addr);
    chk({tag, "_en"}, mem_en, 1);
    chk({tag, "_addr"}, mem_addr, addr);
  endtask

  task automatic reset_chk();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_misalign", misalign_err, 0);
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    reset_chk();
    nx(); nx();
    // Stream from reset: one address per cycle, data two cycles behind.
    reset = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin nx(); #1; end
      issue_chk("t1", 32'(4 * k));
      if (k < 2) chk("t1_vld", instr_valid, 0);
      else head_chk("t1_head", 32'(4 * (k - 2)));
    end
    // Back-pressure with pc=8 at the head.
    nx(); instr_ready = 1'b0; #1;
    chk("t2_en", mem_en, 0); head_chk("t2_hold", 32'h8);
    for (int k = 0; k < 4; k++) begin
      nx(); #1;
      chk("t2_en", mem_en, 0); head_chk("t2_hold", 32'h8);
    end
    nx(); instr_ready = 1'b1; #1;
    issue_chk("t2_rel", 32'h10); head_chk("t2_rel", 32'h8);
    for (int k = 0; k < 3; k++) begin
      nx(); #1;
      issue_chk("t2_run", 32'(32'h14 + 4 * k)); head_chk("t2_run", 32'(32'hC + 4 * k));
    end
    // Redirect to 0x40 with 0x1C in flight.
    nx(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    chk("t3_en", mem_en, 0); head_chk("t3_cur", 32'h18);
    nx(); redirect_valid = 1'b0; #1;
    issue_chk("t3_r1", 32'h40); chk("t3_r1_vld", instr_valid, 0); chk("t3_r1_mis", misalign_err, 0);
    nx(); #1;
    issue_chk("t3_r2", 32'h44); chk("t3_r2_vld", instr_valid, 0);
    nx(); #1;
    head_chk("t3_r3", 32'h40); issue_chk("t3_r3", 32'h48);
    nx(); #1;
    head_chk("t3_r4", 32'h44);
    // Halt: in-flight 0x4C still delivered, then halted.
    nx(); halt_req = 1'b1; #1;
    chk("t4_en", mem_en, 0); chk("t4_halted0", halted, 0); head_chk("t4_h0", 32'h48);
    nx(); #1;
    chk("t4_en1", mem_en, 0); chk("t4_halted1", halted, 0); head_chk("t4_h1", 32'h4C);
    nx(); #1;
    chk("t4_en2", mem_en, 0); chk("t4_halted2", halted, 1); chk("t4_vld2", instr_valid, 0);
    nx(); halt_req = 1'b0; #1;
    chk("t4_en3", mem_en, 0); chk("t4_halted3", halted, 0);
    nx(); #1;
    issue_chk("t4_resume", 32'h50);
    nx(); #1;
    issue_chk("t4_r1", 32'h54); chk("t4_r1_vld", instr_valid, 0);
    nx(); #1;
    head_chk("t4_r2", 32'h50);
    // Misaligned redirect.
    nx(); redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
    chk("t5_en", mem_en, 0); chk("t5_mis0", misalign_err, 0);
    nx(); redirect_valid = 1'b0; #1;
    chk("t5_mis1", misalign_err, 1); issue_chk("t5_r1", 32'h100); chk("t5_r1_vld", instr_valid, 0);
    nx(); #1;
    chk("t5_mis2", misalign_err, 0); issue_chk("t5_r2", 32'h104);
    nx(); instr_ready = 1'b0; #1;
    head_chk("t5_r3", 32'h100); chk("t5_r3_en", mem_en, 0);
    nx(); #1;
    head_chk("t6_full", 32'h100); chk("t6_full_en", mem_en, 0);
    // Asynchronous reset with the buffer full.
    reset = 1'b0; #1;
    reset_chk();
    instr_ready = 1'b1;
    nx(); nx();
    reset = 1'b1; #1;
    issue_chk("t6_c0", 32'h0); chk("t6_c0_vld", instr_valid, 0);
    nx(); #1;
    issue_chk("t6_c1", 32'h4); chk("t6_c1_vld", instr_valid, 0);
    nx(); #1;
    head_chk("t6_c2", 32'h0);
    // PC wrap at the top of the address space.
    nx(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    chk("wrap_en", mem_en, 0);
    nx(); redirect_valid = 1'b0; #1;
    issue_chk("wrap_r1", 32'hFFFF_FFFC); chk("wrap_r1_vld", instr_valid, 0);
    nx(); #1;
    issue_chk("wrap_r2", 32'h0);
    nx(); #1;
    head_chk("wrap_r3", 32'hFFFF_FFFC);
    nx(); #1;
    head_chk("wrap_r4", 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
